// File: rtl/tpu_ctrl_pkg.sv
// Shared types for the TPU control blocks: load-sequencer FSM states and
// the byte width of the register bank data path.
package tpu_ctrl_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/reg_bank_load_ctrl_onehot_dec.sv
// Binary index to one-hot decoder. The output is all-zero when en is low,
// so the caller gets "no write" for free on non-accept cycles.
module onehot_dec #(
  parameter  int NUM_OUT = 8,
  localparam int IDX_W   = $clog2(NUM_OUT)
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_OUT-1:0] onehot
);

  // Set exactly the addressed bit when enabled.
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_load_ctrl.sv
// Load sequencer for a bank of NUM_REGS byte registers fed from one
// valid/ready byte stream. Drives a shared data bus, a registered one-hot
// write enable and a bank-wide clear pulse.
// Optional build macro REG_BANK_CHECKSUM_EN adds a running sum-mod-256
// output of the bytes accepted in the current/last sequence.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready is high for every cycle the FSM is in LOAD and does not depend
// on in_valid. The producer must hold in_data stable while in_valid is high.
module reg_bank_load_ctrl
  import tpu_ctrl_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [DATA_W-1:0]   reg_d,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                reg_clr,
  output logic                busy,
  output logic                done,
  output logic [IDX_W:0]      count,
`ifdef REG_BANK_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  output state_e              dbg_state
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W:0]        count_q, count_d;
  logic [DATA_W-1:0]     reg_d_q, reg_d_d;
  logic [NUM_REGS-1:0]   reg_en_q, reg_en_d;
  logic                  reg_clr_q, reg_clr_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  last_idx;
  logic [NUM_REGS-1:0]   dec_onehot;

  assign accept   = in_valid && (state_q == LOAD);
  assign last_idx = (idx_q == IDX_W'(NUM_REGS - 1));

  onehot_dec #(.NUM_OUT(NUM_REGS)) u_dec (
    .idx    (idx_q),
    .en     (accept),
    .onehot (dec_onehot)
  );

  // Next-state and registered-output logic for the load sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    reg_d_d   = reg_d_q;
    reg_en_d  = dec_onehot;
    reg_clr_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          count_d = '0;
          if (clear) begin
            state_d   = CLEAR;
            reg_clr_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      CLEAR: state_d = abort ? IDLE : LOAD;
      LOAD: begin
        if (accept) begin
          reg_d_d = in_data;
          count_d = count_q + (IDX_W+1)'(1);
          // idx saturates at the last register; only start rewinds it.
          if (!last_idx) idx_d = idx_q + IDX_W'(1);
        end
        // Abort wins over completion; an accepted beat's write still issues.
        if (abort)                   state_d = IDLE;
        else if (accept && last_idx) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      count_q   <= '0;
      reg_d_q   <= '0;
      reg_en_q  <= '0;
      reg_clr_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      reg_d_q   <= reg_d_d;
      reg_en_q  <= reg_en_d;
      reg_clr_q <= reg_clr_d;
      done_q    <= done_d;
    end
  end

`ifdef REG_BANK_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // Running byte sum: cleared by an accepted start, bumped on each accept.
  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start) sum_d = '0;
    else if (accept)              sum_d = sum_q + in_data;
  end

  // Checksum register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign reg_d     = reg_d_q;
  assign reg_en    = reg_en_q;
  assign reg_clr   = reg_clr_q;
  assign done      = done_q;
  assign count     = count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_bank_load_ctrl.sv
// Directed + randomized bench for reg_bank_load_ctrl. A small model tracks
// which beats should be accepted and queues the expected (cycle, enable,
// data) write for each one; every cycle the bus is compared to that queue.
module tb_reg_bank_load_ctrl;
  import tpu_ctrl_pkg::*;

  localparam int NUM_REGS = 8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic                start = 1'b0;
  logic                clear = 1'b0;
  logic                abort = 1'b0;
  logic                in_valid = 1'b0;
  logic [7:0]          in_data = 8'h00;
  logic                in_ready;
  logic [7:0]          reg_d;
  logic [NUM_REGS-1:0] reg_en;
  logic                reg_clr;
  logic                busy;
  logic                done;
  logic [IDX_W:0]      count;
`ifdef REG_BANK_CHECKSUM_EN
  logic [7:0]          checksum;
`endif
  state_e              dbg_state;

  reg_bank_load_ctrl #(.NUM_REGS(NUM_REGS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reg_d     (reg_d),
    .reg_en    (reg_en),
    .reg_clr   (reg_clr),
    .busy      (busy),
    .done      (done),
    .count     (count),
`ifdef REG_BANK_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          exp_done_cyc = -1;
  logic [31:0] exp_q[$];        // {due cycle[15:0], one-hot enable, data}
  bit          m_load = 1'b0;   // model: controller should be taking bytes
  int          m_n = 0;         // model: bytes accepted this sequence
  logic [7:0]  m_sum = 8'h00;   // model: sum mod 256 of accepted bytes

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare the write bus and done against the model.
  task automatic cycle();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0 && exp_q[0][31:16] == cyc[15:0]) begin
      e = exp_q.pop_front();
      chk("reg_en_write", 32'(reg_en), 32'(e[15:8]));
      chk("reg_d_write", 32'(reg_d), 32'(e[7:0]));
    end else begin
      chk("reg_en_quiet", 32'(reg_en), 32'd0);
    end
    chk("done", 32'(done), 32'(cyc == exp_done_cyc));
    chk("reg_en_onehot", 32'($countones(reg_en) <= 1), 32'd1);
    chk("clr_en_overlap", 32'(reg_clr && (reg_en != '0)), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input bit v, input logic [7:0] d, input bit ab);
    in_valid = v;
    in_data  = d;
    abort    = ab;
    chk("in_ready", 32'(in_ready), 32'(m_load));
    if (v && m_load) begin
      exp_q.push_back({cyc[15:0] + 16'd1, 8'(1 << m_n), d});
      m_n++;
      m_sum = m_sum + d;
      if (m_n == NUM_REGS && !ab) begin
        m_load       = 1'b0;
        exp_done_cyc = cyc + 2;
      end
    end
    if (ab) m_load = 1'b0;
    cycle();
    in_valid = 1'b0;
    abort    = 1'b0;
  endtask

  task automatic do_start(input bit cl);
    start    = 1'b1;
    clear    = cl;
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    chk("in_ready_idle", 32'(in_ready), 32'd0);
    cycle();
    start = 1'b0;
    clear = 1'b0;
    m_n   = 0;
    m_sum = 8'h00;
    chk("busy_started", 32'(busy), 32'd1);
    if (cl) begin
      chk("reg_clr_pulse", 32'(reg_clr), 32'd1);
      chk("in_ready_clear", 32'(in_ready), 32'd0);
      cycle();
      chk("reg_clr_single", 32'(reg_clr), 32'd0);
    end
    in_valid = 1'b0;
    m_load   = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_beat(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_end(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(m_n));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef REG_BANK_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum), 32'(m_sum));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_reg_en"}, 32'(reg_en), 32'd0);
    chk({tag, "_reg_clr"}, 32'(reg_clr), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_reg_d"}, 32'(reg_d), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
`ifdef REG_BANK_CHECKSUM_EN
    chk({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit   pat[7];
    bit   v;
    bit   ab;
    int   guard;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;

    // Full load, no clear, bytes 0x10..0x17 back to back.
    do_start(1'b0);
    for (int i = 0; i < NUM_REGS; i++) drive_beat(1'b1, 8'(8'h10 + i), 1'b0);
    idle(3);
    check_end("full");
    idle(2);
    chk("count_hold", 32'(count), 32'd8);

    // Load preceded by a bank clear.
    do_start(1'b1);
    for (int i = 0; i < NUM_REGS; i++) drive_beat(1'b1, 8'($urandom), 1'b0);
    idle(3);
    check_end("clear");

    // Backpressure gaps, then an abort with no accept.
    do_start(1'b0);
    for (int i = 0; i < 7; i++) drive_beat(pat[i], 8'($urandom), 1'b0);
    drive_beat(1'b0, 8'h00, 1'b1);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    idle(2);
    check_end("gaps");
    chk("gaps_count4", 32'(count), 32'd4);

    // Abort coinciding with the 3rd accept; start mid-sequence ignored.
    do_start(1'b0);
    drive_beat(1'b1, 8'($urandom), 1'b0);
    start = 1'b1;
    clear = 1'b1;
    drive_beat(1'b1, 8'($urandom), 1'b0);
    start = 1'b0;
    clear = 1'b0;
    drive_beat(1'b1, 8'($urandom), 1'b1);
    chk("abort_accept_busy", 32'(busy), 32'd0);
    idle(3);
    check_end("abort");
    chk("abort_count3", 32'(count), 32'd3);

    // Asynchronous reset after the 5th accept, then a fresh load.
    do_start(1'b0);
    for (int i = 0; i < 5; i++) drive_beat(1'b1, 8'($urandom), 1'b0);
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b1;
    exp_q.delete();
    m_load = 1'b0;
    m_n = 0;
    m_sum = 8'h00;
    exp_done_cyc = -1;
    check_reset_outputs("reset_held");
    do_start(1'b0);
    for (int i = 0; i < 3; i++) drive_beat(1'b1, 8'($urandom), 1'b0);
    drive_beat(1'b0, 8'h00, 1'b1);
    idle(2);
    check_end("reload");

    // Randomized sequences: random clear, valid gaps and rare aborts.
    for (int s = 0; s < 8; s++) begin
      do_start(1'($urandom_range(0, 1)));
      guard = 0;
      while (m_load && guard < 60) begin
        v  = ($urandom_range(0, 3) != 0);
        ab = ($urandom_range(0, 24) == 0);
        drive_beat(v, 8'($urandom), ab);
        guard++;
      end
      if (m_load) drive_beat(1'b0, 8'h00, 1'b1);
      idle(3);
      check_end("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
